// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue
//   Collects ALU and load results over valid/ready handshakes into a
//   DEPTH-entry FIFO and drains one entry per cycle onto the registered
//   register-file write port. Also reports which registers have writes in
//   flight, so that issue logic can stall reads of them.
//
// Ports
//   clock, reset            rising-edge clock; asynchronous active-low reset
//   alu_valid/ready/reg/data ALU producer handshake and payload
//   ld_valid/ready/reg/data  load producer handshake and payload
//   rf_write/rf_reg/rf_data  registered register-file write port
//   rd_reg1/rd_reg2          registers queried for pending writes
//   pend1/pend2              combinational pending status of rd_reg1/rd_reg2
//   busy_mask                per-register in-flight write mask
//   count                    FIFO occupancy, excluding the output register
module rf_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_reg,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_reg,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_reg,
  output logic [DATA_W-1:0]        rf_data,
  input  logic [ADDR_W-1:0]        rd_reg1,
  input  logic [ADDR_W-1:0]        rd_reg2,
  output logic                     pend1,
  output logic                     pend2,
  output logic [(1<<ADDR_W)-1:0]   busy_mask,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] q_reg  [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] alu_slot;
  logic             rr;
  logic             pop;
  logic [CNT_W:0]   free;
  logic             free_one;
  logic             free_many;
  logic             contend;
  logic             acc_ld;
  logic             acc_alu;

  // The head leaves every cycle the FIFO is non-empty, so its slot is
  // reusable on the same edge.
  always_comb begin
    pop       = (count != '0);
    free      = (CNT_W+1)'(DEPTH) - (CNT_W+1)'(count) + (CNT_W+1)'(pop);
    free_one  = (free == (CNT_W+1)'(1));
    free_many = (free >  (CNT_W+1)'(1));
    contend   = free_one && alu_valid && ld_valid;
    ld_ready  = 1'b0;
    alu_ready = 1'b0;
    if (free_many) begin
      ld_ready  = 1'b1;
      alu_ready = 1'b1;
    end else if (free_one) begin
      // Single slot: an uncontested producer takes it, otherwise rr picks.
      ld_ready  = !alu_valid || !rr;
      alu_ready = !ld_valid  ||  rr;
    end
    acc_ld   = ld_valid  && ld_ready;
    acc_alu  = alu_valid && alu_ready;
    // Load entry goes ahead of the ALU entry on a dual accept.
    alu_slot = wptr + PTR_W'(acc_ld);
  end

  // Storage carries no reset: only pointers/count decide what is valid.
  always_ff @(posedge clock) begin
    if (acc_ld) begin
      q_reg[wptr]  <= ld_reg;
      q_data[wptr] <= ld_data;
    end
    if (acc_alu) begin
      q_reg[alu_slot]  <= alu_reg;
      q_data[alu_slot] <= alu_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rr       <= 1'b0;
      rf_write <= 1'b0;
      rf_reg   <= '0;
      rf_data  <= '0;
    end else begin
      wptr     <= wptr + PTR_W'(acc_ld) + PTR_W'(acc_alu);
      rptr     <= rptr + PTR_W'(pop);
      count    <= count + CNT_W'(acc_ld) + CNT_W'(acc_alu) - CNT_W'(pop);
      rf_write <= pop;
      if (contend) rr <= ~rr;
      if (pop) begin
        rf_reg  <= q_reg[rptr];
        rf_data <= q_data[rptr];
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count)
        busy_mask[q_reg[PTR_W'(rptr + PTR_W'(i))]] = 1'b1;
    end
    if (rf_write) busy_mask[rf_reg] = 1'b1;
    pend1 = busy_mask[rd_reg1];
    pend2 = busy_mask[rd_reg2];
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb_rf_writeback_queue
//   Directed bench for rf_writeback_queue (DEPTH=4, DATA_W=32, ADDR_W=5).
//   Inputs are driven 1ns after the rising edge and outputs are sampled
//   1-2ns after it; expected values are hand-derived constants.
module tb_rf_writeback_queue;

  logic        clock;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_reg;
  logic [31:0] ld_data;
  logic        rf_write;
  logic [4:0]  rf_reg;
  logic [31:0] rf_data;
  logic [4:0]  rd_reg1, rd_reg2;
  logic        pend1, pend2;
  logic [31:0] busy_mask;
  logic [2:0]  count;

  int n_vec = 0;
  int n_err = 0;

  rf_writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .rf_write(rf_write), .rf_reg(rf_reg), .rf_data(rf_data),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .pend1(pend1), .pend2(pend2),
    .busy_mask(busy_mask), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Fill-phase grant table (both producers valid, rr=0 at start).
  bit       exp_ld_rdy  [8] = '{1, 1, 1, 1, 0, 1, 0, 1};
  bit       exp_alu_rdy [8] = '{1, 1, 1, 0, 1, 0, 1, 0};
  int       exp_cnt     [8] = '{0, 2, 3, 4, 4, 4, 4, 4};

  int ld_n, alu_n;
  bit acc_l, acc_a;

  initial begin
    reset = 1'b0;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_reg  = '0; ld_data  = '0;
    rd_reg1 = 5'd7; rd_reg2 = 5'd12;

    // Reset state
    #2;
    check("rst_rf_write", rf_write, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy_mask, 0);
    check("rst_pend", {pend1, pend2}, 0);
    check("rst_ready", {ld_ready, alu_ready}, 2'b11);
    #10 reset = 1'b1;
    tick();

    // Single write
    ld_valid = 1'b1; ld_reg = 5'd7; ld_data = 32'hDEADBEEF;
    #1;
    check("sw_ld_ready", ld_ready, 1);
    check("sw_pend_pre", pend1, 0);
    tick();
    ld_valid = 1'b0;
    check("sw_count1", count, 1);
    check("sw_wr_early", rf_write, 0);
    check("sw_pend_q", pend1, 1);
    tick();
    check("sw_wr", {rf_write, rf_reg}, {1'b1, 5'd7});
    check("sw_data", rf_data, 32'hDEADBEEF);
    check("sw_pend_rf", pend1, 1);
    check("sw_count0", count, 0);
    tick();
    check("sw_wr_off", rf_write, 0);
    check("sw_hold", {rf_reg, rf_data}, {5'd7, 32'hDEADBEEF});
    check("sw_pend_off", pend1, 0);

    // Dual accept ordering: ld ahead of alu
    ld_valid = 1'b1; ld_reg = 5'd3; ld_data = 32'h11;
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h22;
    #1;
    check("dual_ready", {ld_ready, alu_ready}, 2'b11);
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0;
    check("dual_count", count, 2);
    tick();
    check("dual_first", {rf_write, rf_reg, rf_data}, {1'b1, 5'd3, 32'h11});
    tick();
    check("dual_second", {rf_write, rf_reg, rf_data}, {1'b1, 5'd3, 32'h22});
    tick();
    check("dual_done", rf_write, 0);

    // Fill and back-pressure: ld offers 1,3,5,..., alu offers 2,4,6,...
    ld_n = 0; alu_n = 0;
    for (int i = 0; i < 13; i++) begin
      ld_valid  = (i < 8);
      alu_valid = (i < 8);
      ld_reg = 5'd1; alu_reg = 5'd2;
      ld_data  = 32'(2 * ld_n + 1);
      alu_data = 32'(2 * alu_n + 2);
      #1;
      if (i < 8) begin
        check($sformatf("fill_ld_rdy%0d", i), ld_ready, exp_ld_rdy[i]);
        check($sformatf("fill_alu_rdy%0d", i), alu_ready, exp_alu_rdy[i]);
        check($sformatf("fill_cnt%0d", i), count, exp_cnt[i]);
      end
      acc_l = ld_valid && ld_ready;
      acc_a = alu_valid && alu_ready;
      tick();
      if (acc_l) ld_n++;
      if (acc_a) alu_n++;
      check($sformatf("fill_wr%0d", i), rf_write, (i >= 1 && i <= 11));
      if (i >= 1 && i <= 11) check($sformatf("fill_data%0d", i), rf_data, i);
    end
    check("fill_empty", count, 0);

    // Wrap-around: 20 single loads, registers 0..19
    for (int i = 0; i < 22; i++) begin
      ld_valid = (i < 20);
      ld_reg   = 5'(i);
      ld_data  = 32'(32'h100 + i);
      #1;
      if (i < 20) check($sformatf("wrap_rdy%0d", i), ld_ready, 1);
      tick();
      if (i >= 1 && i <= 20)
        check($sformatf("wrap_wr%0d", i), {rf_write, rf_reg, rf_data},
              {1'b1, 5'(i - 1), 32'(32'h100 + i - 1)});
      if (i >= 1 && i <= 19)
        check($sformatf("wrap_busy%0d", i), busy_mask, (64'd1 << i) | (64'd1 << (i - 1)));
    end
    check("wrap_wr_off", rf_write, 0);
    check("wrap_count", count, 0);
    check("wrap_busy", busy_mask, 0);

    // Reset mid-operation with count=3 and rf_write=1
    ld_valid = 1'b1; ld_reg = 5'd20; ld_data = 32'hA0;
    alu_valid = 1'b1; alu_reg = 5'd21; alu_data = 32'hA1;
    tick();
    ld_reg = 5'd22; ld_data = 32'hA2;
    alu_reg = 5'd23; alu_data = 32'hA3;
    tick();
    check("mid_count", count, 3);
    check("mid_wr", rf_write, 1);
    check("mid_busy", busy_mask, 32'h00F0_0000);
    ld_valid = 1'b0; alu_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("mid_rst_wr", rf_write, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_busy", busy_mask, 0);
    check("mid_rst_rf", {rf_reg, rf_data}, 0);
    check("mid_rst_ready", {ld_ready, alu_ready}, 2'b11);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mid_quiet%0d", i), {rf_write, count}, 0);
    end

    // Pending query: registers 5 and 9 queued
    rd_reg1 = 5'd5; rd_reg2 = 5'd12;
    ld_valid = 1'b1; ld_reg = 5'd5; ld_data = 32'h55;
    alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'h99;
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0;
    #1;
    check("pq_busy", busy_mask, 32'h0000_0220);
    check("pq_pend", {pend1, pend2}, 2'b10);
    tick();
    check("pq_busy_rf", busy_mask, 32'h0000_0220);
    check("pq_rf5", {rf_write, rf_reg, rf_data}, {1'b1, 5'd5, 32'h55});
    tick();
    rd_reg2 = 5'd9;
    #1;
    check("pq_busy9", busy_mask, 32'h0000_0200);
    check("pq_pend9", {pend1, pend2}, 2'b01);
    tick();
    check("pq_clear", {busy_mask, pend1, pend2}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_writeback_queue.md
# rf_writeback_queue

Writeback initiator for the 32 x 32-bit register file. Accepts results from two producers, the ALU and the load unit, over valid/ready handshakes and buffers them in a DEPTH-entry FIFO. It drains one entry per cycle onto the register file write port (write enable, register number, data). It also reports per-register pending-write status so issue logic can stall reads of registers with in-flight writes.

## Interface
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- DATA_W, 32: data width.
- ADDR_W, 5: register number width.

Ports:
- clock  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this edge when alu_valid is also high.
- alu_reg  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load result accepted this edge when ld_valid is also high.
- ld_reg  in  ADDR_W  load destination register.
- ld_data  in  DATA_W  load result.
- rf_write  out  1  register file write enable; registered.
- rf_reg  out  ADDR_W  register file write register number; registered.
- rf_data  out  DATA_W  register file write data; registered.
- rd_reg1, rd_reg2  in  ADDR_W  registers queried for pending writes.
- pend1, pend2  out  1  a write to rd_reg1 / rd_reg2 is in flight; combinational.
- busy_mask  out  2^ADDR_W  bit r set while any write to register r is in flight.
- count  out  clog2(DEPTH)+1  number of FIFO entries, excluding the output register.

## Operation
- **FIFO entries:** each entry holds {reg, data}. Write and read pointers are clog2(DEPTH) bits and wrap modulo DEPTH. count ranges from 0 to DEPTH.
- **Drain:** at every edge with count > 0, the head entry moves into {rf_reg, rf_data}, rf_write is set to 1, and count decrements. With count == 0, rf_write goes to 0; rf_reg and rf_data hold their values. The write port never back-pressures.
- **Free slots:** free = DEPTH - count + (count != 0 ? 1 : 0). A pop in the same edge frees a slot.
- **Grant rules:**
  - free >= 2: both ready outputs are 1.
  - free == 1: exactly one producer is granted. If only one producer is valid, that producer gets the slot. If both are valid, the round-robin bit rr decides: rr=0 grants ld, rr=1 grants alu.
  - free == 0: both ready outputs are 0.
- **Round-robin update:** rr toggles only on an edge where a contended single slot was granted.
- **Ordering:** when both producers are accepted on the same edge, the ld entry is placed ahead of the alu entry. Writes to the same register reach the register file in acceptance order.
- **No filtering:** register 0 is written like any other register. No merging or squashing of duplicate destinations.
- **Pending status:**
  - busy_mask[r] = OR over valid FIFO entries with reg == r, OR (rf_write && rf_reg == r).
  - pend1 = busy_mask[rd_reg1]; pend2 = busy_mask[rd_reg2].
  - Entries accepted on the current edge appear in busy_mask in the following cycle.
- **Reset:** the asynchronous reset clears pointers, count, rr, rf_write, rf_reg and rf_data to 0. Queued and presented entries are discarded and never written. Immediately after reset, busy_mask = 0, pend1 = pend2 = 0, and alu_ready = ld_ready = 1.

## Timing
- An entry accepted at edge k into an empty FIFO is popped at edge k+1. rf_write is high during cycle k+1..k+2, and the register file captures the data at edge k+2.
- Sustained throughput is one write per cycle. Two accepts per cycle are possible only in bursts, until the FIFO fills.
- rf_write, rf_reg and rf_data change only on clock edges; they are glitch-free and stable for a full cycle.
- Ready outputs are combinational from count, rr and the other producer's valid. Valid must not depend on ready.
- Boundaries:
  - Full (count == DEPTH): free = 1, pop and accept occur on the same edge, and count stays at DEPTH.
  - Pointer wrap from DEPTH-1 to 0 must preserve order.
  - Reset asserted mid-burst: all outputs go to 0 asynchronously. After release, the first accept behaves as if the FIFO were empty.

## Test plan
- **Single write:** reset, then ld_valid=1, ld_reg=7, ld_data=0xDEADBEEF for one cycle. Required: ld_ready=1; one cycle later rf_write=1, rf_reg=7, rf_data=0xDEADBEEF for exactly one cycle; pend1=1 for rd_reg1=7 from the cycle after accept until the cycle after rf_write falls.
- **Dual accept ordering:** empty FIFO; same cycle, ld {3, 0x11} and alu {3, 0x22}. Required: both ready; rf_reg=3 with 0x11, then 0x22 on consecutive cycles.
- **Fill and back-pressure:** DEPTH=4; both producers valid every cycle with incrementing data 1,2,3,… Required: count reaches 4, then stays 4 with one grant per cycle; grants alternate ld, alu, ld, …; rf_data sequence matches acceptance order with no loss or duplication.
- **Wrap-around:** 20 single ld writes to registers 0..19, data = 0x100 + r. Required: 20 rf writes, in order, with correct data; count returns to 0 and busy_mask returns to 0.
- **Reset mid-operation:** with count=3 and rf_write=1, pulse reset low between edges. Required: rf_write, count and busy_mask go to 0 immediately; none of the queued entries is ever written.
- **Pending query:** queue writes to registers 5 and 9; rd_reg1=5, rd_reg2=12. Required: pend1=1, pend2=0; busy_mask = 0x00000220 while both are queued.
